// File: rtl/atm_multi_account_ctrl_if.sv
// Session bus between the ATM front panel and atm_multi_account_ctrl.
// ATM_TRANSFER_EN adds the transfer request and destination signals.
interface atm_multi_account_ctrl_if #(
    parameter int unsigned CARD_W = 8,
    parameter int unsigned PIN_W  = 16,
    parameter int unsigned BAL_W  = 24
);
    logic              card_inserted;
    logic [CARD_W-1:0] card_number_input;
    logic [PIN_W-1:0]  pin_input;
    logic              pin_valid;
    logic              balance_req;
    logic              withdrawal_req;
    logic              deposit_req;
    logic              pin_change_req;
    logic [BAL_W-1:0]  amount;
    logic              transaction_done;
    logic              end_session;
`ifdef ATM_TRANSFER_EN
    logic              xfer_req;
    logic [CARD_W-1:0] xfer_dest;
`endif
    logic [7:0]        current_state;
    logic [BAL_W-1:0]  balance;
    logic              transaction_success;
    logic [7:0]        error_code;
    logic              card_eject;

    modport master (
        input  current_state, balance, transaction_success, error_code, card_eject,
        output card_inserted, card_number_input, pin_input, pin_valid,
               balance_req, withdrawal_req, deposit_req, pin_change_req,
               amount, transaction_done, end_session
`ifdef ATM_TRANSFER_EN
               , xfer_req, xfer_dest
`endif
    );

    modport slave (
        output current_state, balance, transaction_success, error_code, card_eject,
        input  card_inserted, card_number_input, pin_input, pin_valid,
               balance_req, withdrawal_req, deposit_req, pin_change_req,
               amount, transaction_done, end_session
`ifdef ATM_TRANSFER_EN
               , xfer_req, xfer_dest
`endif
    );
endinterface

// File: rtl/atm_multi_account_ctrl.sv
// Multi-account ATM session controller: card check, PIN handshake, menu transactions.
// Defining ATM_TRANSFER_EN builds the account-to-account transfer transaction.
module atm_multi_account_ctrl #(
    parameter int unsigned NUM_ACCTS   = 8,
    parameter int unsigned CARD_W      = 8,
    parameter int unsigned PIN_W       = 16,
    parameter int unsigned BAL_W       = 24,
    parameter int unsigned INIT_BAL    = 1000,
    parameter int unsigned PIN_BASE    = 'h1234,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned WDL_LIMIT   = 500
) (
    input logic                     clk,
    input logic                     rst_n,
    atm_multi_account_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1;
    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CARD_W:0]  NACC     = (CARD_W + 1)'(NUM_ACCTS);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [BAL_W:0]   WDL_MAX  = (BAL_W + 1)'(WDL_LIMIT);
    localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);

    localparam logic [7:0] E_NONE    = 8'h00;
    localparam logic [7:0] E_CARD    = 8'h01;
    localparam logic [7:0] E_PIN     = 8'h02;
    localparam logic [7:0] E_LOCK    = 8'h03;
    localparam logic [7:0] E_FUNDS   = 8'h04;
    localparam logic [7:0] E_LIMIT   = 8'h05;
    localparam logic [7:0] E_TMO     = 8'h06;
    localparam logic [7:0] E_REMOVED = 8'h07;
    localparam logic [7:0] E_OVF     = 8'h08;
    localparam logic [7:0] E_ZERO    = 8'h09;

    typedef enum logic [7:0] {
        S_IDLE       = 8'h00,
        S_CARD_CHECK = 8'h01,
        S_PIN_WAIT   = 8'h02,
        S_PIN_CHECK  = 8'h03,
        S_MENU       = 8'h04,
        S_EXEC       = 8'h05,
        S_RESULT     = 8'h06,
        S_EJECT      = 8'h07
    } state_t;

    typedef enum logic [2:0] {OP_BAL, OP_WDL, OP_DEP, OP_PIN, OP_XFER} op_t;

    state_t            state_q;
    op_t               op_q;
    logic [BAL_W-1:0]  amt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [PIN_W-1:0]  pin_in_q;
    logic [BAL_W:0]    sess_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [BAL_W-1:0]  bal_out_q;
    logic              succ_q;
    logic [7:0]        err_q;

    logic [BAL_W-1:0]     acct_bal_q   [NUM_ACCTS];
    logic [PIN_W-1:0]     acct_pin_q   [NUM_ACCTS];
    logic [TRY_W-1:0]     acct_tries_q [NUM_ACCTS];
    logic [NUM_ACCTS-1:0] acct_lock_q;

    logic [IDX_W-1:0] card_idx;
    logic             card_ok;
    logic [BAL_W-1:0] cur_bal;
    logic [TRY_W-1:0] tries_inc;
    logic             menu_req, any_strobe, timed, removed, tmo_hit, tmo_fire;
    op_t              menu_op;
    logic [BAL_W:0]   dep_sum, sess_d;
    logic [BAL_W-1:0] exec_bal_d;
    logic [7:0]       exec_err;

`ifdef ATM_TRANSFER_EN
    logic [IDX_W-1:0] dst_idx_q;
    logic             dst_ok_q;
    logic [BAL_W-1:0] dst_bal_d;
    logic [BAL_W:0]   xfer_sum;
`endif

    assign card_idx  = bus.card_number_input[IDX_W-1:0];
    assign card_ok   = {1'b0, bus.card_number_input} < NACC;
    assign cur_bal   = acct_bal_q[idx_q];
    assign tries_inc = acct_tries_q[idx_q] + 1'b1;

    // Fixed request priority: balance > withdrawal > deposit > pin change > transfer.
    always_comb begin
        menu_req = bus.balance_req | bus.withdrawal_req | bus.deposit_req | bus.pin_change_req;
        menu_op  = OP_BAL;
        if (bus.balance_req)         menu_op = OP_BAL;
        else if (bus.withdrawal_req) menu_op = OP_WDL;
        else if (bus.deposit_req)    menu_op = OP_DEP;
        else if (bus.pin_change_req) menu_op = OP_PIN;
`ifdef ATM_TRANSFER_EN
        else if (bus.xfer_req)       menu_op = OP_XFER;
        menu_req = menu_req | bus.xfer_req;
`endif
    end

    assign any_strobe = menu_req | bus.pin_valid | bus.transaction_done | bus.end_session;
    assign timed      = (state_q == S_PIN_WAIT) || (state_q == S_MENU) || (state_q == S_RESULT) ||
                        ((state_q == S_EXEC) && (op_q == OP_PIN));
    assign removed    = !bus.card_inserted && (state_q != S_IDLE) && (state_q != S_EJECT);
    assign tmo_hit    = (tmo_q == TMO_LAST);
    assign tmo_fire   = timed && !any_strobe && tmo_hit;

    // Outcome of the registered transaction; sums carry one extra bit so overflow never wraps.
    always_comb begin
        dep_sum    = {1'b0, cur_bal} + {1'b0, amt_q};
        sess_d     = sess_q + {1'b0, amt_q};
        exec_bal_d = cur_bal;
        exec_err   = E_NONE;
`ifdef ATM_TRANSFER_EN
        dst_bal_d  = acct_bal_q[dst_idx_q];
        xfer_sum   = {1'b0, dst_bal_d} + {1'b0, amt_q};
`endif
        case (op_q)
            OP_WDL: begin
                if (amt_q == '0)            exec_err = E_ZERO;
                else if (amt_q > cur_bal)   exec_err = E_FUNDS;
                else if (sess_d > WDL_MAX)  exec_err = E_LIMIT;
                else                        exec_bal_d = cur_bal - amt_q;
            end
            OP_DEP: begin
                if (amt_q == '0)            exec_err = E_ZERO;
                else if (dep_sum[BAL_W])    exec_err = E_OVF;
                else                        exec_bal_d = dep_sum[BAL_W-1:0];
            end
`ifdef ATM_TRANSFER_EN
            OP_XFER: begin
                if (!dst_ok_q || (dst_idx_q == idx_q)) exec_err = E_CARD;
                else if (amt_q > cur_bal)              exec_err = E_FUNDS;
                else if (xfer_sum[BAL_W])              exec_err = E_OVF;
                else if (amt_q == '0)                  exec_err = E_ZERO;
                else begin
                    exec_bal_d = cur_bal - amt_q;
                    dst_bal_d  = xfer_sum[BAL_W-1:0];
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_BAL;
            amt_q       <= '0;
            idx_q       <= '0;
            pin_in_q    <= '0;
            sess_q      <= '0;
            tmo_q       <= '0;
            bal_out_q   <= '0;
            succ_q      <= 1'b0;
            err_q       <= E_NONE;
            acct_lock_q <= '0;
            for (int unsigned i = 0; i < NUM_ACCTS; i++) begin
                acct_bal_q[i]   <= BAL_W'(INIT_BAL);
                acct_pin_q[i]   <= PIN_W'(PIN_BASE + i);
                acct_tries_q[i] <= '0;
            end
`ifdef ATM_TRANSFER_EN
            dst_idx_q   <= '0;
            dst_ok_q    <= 1'b0;
`endif
        end else begin
            // Waiting states only stay put without a strobe, so any state change also clears this.
            tmo_q <= (timed && !any_strobe && !tmo_hit && !removed) ? tmo_q + 1'b1 : '0;

            if (removed) begin
                err_q     <= E_REMOVED;
                succ_q    <= 1'b0;
                bal_out_q <= '0;
                state_q   <= S_IDLE;
            end else if (tmo_fire) begin
                err_q   <= E_TMO;
                succ_q  <= 1'b0;
                state_q <= S_EJECT;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        err_q  <= E_NONE;
                        sess_q <= '0;
                        if (bus.card_inserted) state_q <= S_CARD_CHECK;
                    end
                    S_CARD_CHECK: begin
                        if (!card_ok) begin
                            err_q   <= E_CARD;
                            state_q <= S_EJECT;
                        end else if (acct_lock_q[card_idx]) begin
                            err_q   <= E_LOCK;
                            state_q <= S_EJECT;
                        end else begin
                            idx_q   <= card_idx;
                            state_q <= S_PIN_WAIT;
                        end
                    end
                    S_PIN_WAIT: begin
                        if (bus.pin_valid) begin
                            pin_in_q <= bus.pin_input;
                            state_q  <= S_PIN_CHECK;
                        end
                    end
                    S_PIN_CHECK: begin
                        if (pin_in_q == acct_pin_q[idx_q]) begin
                            acct_tries_q[idx_q] <= '0;
                            err_q               <= E_NONE;
                            state_q             <= S_MENU;
                        end else if (tries_inc >= TRY_MAX) begin
                            acct_tries_q[idx_q] <= tries_inc;
                            acct_lock_q[idx_q]  <= 1'b1;
                            err_q               <= E_LOCK;
                            state_q             <= S_EJECT;
                        end else begin
                            acct_tries_q[idx_q] <= tries_inc;
                            err_q               <= E_PIN;
                            state_q             <= S_PIN_WAIT;
                        end
                    end
                    S_MENU: begin
                        if (bus.end_session) begin
                            state_q <= S_EJECT;
                        end else if (menu_req) begin
                            op_q    <= menu_op;
                            amt_q   <= bus.amount;
                            state_q <= S_EXEC;
`ifdef ATM_TRANSFER_EN
                            dst_idx_q <= bus.xfer_dest[IDX_W-1:0];
                            dst_ok_q  <= {1'b0, bus.xfer_dest} < NACC;
`endif
                        end
                    end
                    S_EXEC: begin
                        if (op_q == OP_PIN) begin
                            if (bus.pin_valid) begin
                                acct_pin_q[idx_q] <= bus.pin_input;
                                succ_q            <= 1'b1;
                                err_q             <= E_NONE;
                                bal_out_q         <= cur_bal;
                                state_q           <= S_RESULT;
                            end
                        end else begin
                            acct_bal_q[idx_q] <= exec_bal_d;
`ifdef ATM_TRANSFER_EN
                            if ((op_q == OP_XFER) && (exec_err == E_NONE))
                                acct_bal_q[dst_idx_q] <= dst_bal_d;
`endif
                            if ((op_q == OP_WDL) && (exec_err == E_NONE)) sess_q <= sess_d;
                            succ_q    <= (exec_err == E_NONE);
                            err_q     <= exec_err;
                            bal_out_q <= exec_bal_d;
                            state_q   <= S_RESULT;
                        end
                    end
                    S_RESULT: begin
                        if (bus.transaction_done) begin
                            succ_q  <= 1'b0;
                            state_q <= S_MENU;
                        end
                    end
                    S_EJECT: begin
                        bal_out_q <= '0;
                        if (!bus.card_inserted) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.current_state       = state_q;
    assign bus.balance             = bal_out_q;
    assign bus.transaction_success = succ_q;
    assign bus.error_code          = err_q;
    assign bus.card_eject          = (state_q == S_EJECT);
endmodule

// File: tb/tb_atm_multi_account_ctrl.sv
// Self-checking bench for atm_multi_account_ctrl: directed table, corner sequences,
// and random sessions scored against a transaction-level account model.
module tb_atm_multi_account_ctrl;
    localparam int CARD_W = 8;
    localparam int PIN_W  = 16;
    localparam int BAL_W  = 24;
    localparam int NACC   = 8;
    localparam longint WDL    = 500;
    localparam longint BALMAX = (longint'(1) << BAL_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    atm_multi_account_ctrl_if #(.CARD_W(CARD_W), .PIN_W(PIN_W), .BAL_W(BAL_W)) bus ();

    atm_multi_account_ctrl #(
        .NUM_ACCTS(NACC), .CARD_W(CARD_W), .PIN_W(PIN_W), .BAL_W(BAL_W),
        .INIT_BAL(1000), .PIN_BASE('h1234), .MAX_TRIES(3), .TIMEOUT_CYC(1000), .WDL_LIMIT(500)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    longint m_bal   [NACC];
    int     m_pin   [NACC];
    int     m_tries [NACC];
    bit     m_lock  [NACC];
    longint m_sess;

    typedef struct {
        logic [2:0]  strb;   // {deposit, withdrawal, balance}
        logic [23:0] amt;
        logic [7:0]  e;
        logic        ok;
        logic [23:0] bal;
    } vec_t;
    vec_t tbl [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Account rules applied to whole transactions; the winner is picked by request rank.
    task automatic model_op(input int c, input logic [2:0] strb, input longint amt, output logic [7:0] e);
        e = 8'h00;
        if (strb[0]) begin
            e = 8'h00;
        end else if (strb[1]) begin
            if (amt == 0)                 e = 8'h09;
            else if (amt > m_bal[c])      e = 8'h04;
            else if (m_sess + amt > WDL)  e = 8'h05;
            else begin
                m_bal[c] -= amt;
                m_sess   += amt;
            end
        end else if (strb[2]) begin
            if (amt == 0)                    e = 8'h09;
            else if (m_bal[c] + amt > BALMAX) e = 8'h08;
            else m_bal[c] += amt;
        end
    endtask

    task automatic insert(input int c);
        bus.card_number_input = CARD_W'(c);
        bus.card_inserted     = 1'b1;
        step();
        chk("card_check", bus.current_state, 8'h01);
        step();
        m_sess = 0;
    endtask

    task automatic pin(input logic [15:0] p);
        bus.pin_input = p;
        bus.pin_valid = 1'b1;
        step();
        bus.pin_valid = 1'b0;
        step();
    endtask

    task automatic pull();
        bus.card_inserted = 1'b0;
        step();
        chk("to_idle", bus.current_state, 8'h00);
    endtask

    task automatic end_sess();
        bus.end_session = 1'b1;
        step();
        bus.end_session = 1'b0;
        chk("eject", bus.card_eject, 1'b1);
        pull();
    endtask

    task automatic do_req(input string nm, input logic [2:0] strb, input logic [23:0] amt,
                          input logic [7:0] e, input logic ok, input logic [23:0] b);
        {bus.deposit_req, bus.withdrawal_req, bus.balance_req} = strb;
        bus.amount = amt;
        step();
        {bus.deposit_req, bus.withdrawal_req, bus.balance_req} = 3'b000;
        step();
        chk({nm, " state"},   bus.current_state, 8'h06);
        chk({nm, " err"},     bus.error_code, e);
        chk({nm, " success"}, bus.transaction_success, ok);
        chk({nm, " balance"}, bus.balance, b);
        bus.transaction_done = 1'b1;
        step();
        bus.transaction_done = 1'b0;
        chk({nm, " menu"},    bus.current_state, 8'h04);
        chk({nm, " cleared"}, bus.transaction_success, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time exhausted, want self-termination");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  e;
        logic [2:0]  s;
        logic [23:0] a;
        int          c;
        int          nops;

        tbl[0]  = '{3'b001, 24'd0,        8'h00, 1'b1, 24'd1000};
        tbl[1]  = '{3'b010, 24'h00FFFF,   8'h04, 1'b0, 24'd1000};
        tbl[2]  = '{3'b010, 24'd300,      8'h00, 1'b1, 24'd700};
        tbl[3]  = '{3'b010, 24'd250,      8'h05, 1'b0, 24'd700};
        tbl[4]  = '{3'b100, 24'hFFFFFF,   8'h08, 1'b0, 24'd700};
        tbl[5]  = '{3'b100, 24'h000100,   8'h00, 1'b1, 24'd956};
        tbl[6]  = '{3'b010, 24'd0,        8'h09, 1'b0, 24'd956};
        tbl[7]  = '{3'b100, 24'd0,        8'h09, 1'b0, 24'd956};
        tbl[8]  = '{3'b011, 24'd100,      8'h00, 1'b1, 24'd956};
        tbl[9]  = '{3'b110, 24'd200,      8'h00, 1'b1, 24'd756};
        tbl[10] = '{3'b010, 24'd1,        8'h05, 1'b0, 24'd756};
        tbl[11] = '{3'b100, 24'd16776459, 8'h00, 1'b1, 24'hFFFFFF};
        tbl[12] = '{3'b100, 24'd1,        8'h08, 1'b0, 24'hFFFFFF};

        for (int i = 0; i < NACC; i++) begin
            m_bal[i]   = 1000;
            m_pin[i]   = 'h1234 + i;
            m_tries[i] = 0;
            m_lock[i]  = 1'b0;
        end
        m_sess = 0;

        bus.card_inserted = 1'b0; bus.card_number_input = '0; bus.pin_input = '0;
        bus.pin_valid = 1'b0; bus.balance_req = 1'b0; bus.withdrawal_req = 1'b0;
        bus.deposit_req = 1'b0; bus.pin_change_req = 1'b0; bus.amount = '0;
        bus.transaction_done = 1'b0; bus.end_session = 1'b0;
`ifdef ATM_TRANSFER_EN
        bus.xfer_req = 1'b0; bus.xfer_dest = '0;
`endif
        rst_n = 1'b0;
        #1;
        chk("rst state",   bus.current_state, 8'h00);
        chk("rst balance", bus.balance, 24'd0);
        chk("rst success", bus.transaction_success, 1'b0);
        chk("rst err",     bus.error_code, 8'h00);
        chk("rst eject",   bus.card_eject, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Directed transaction table on card 0
        insert(0);
        chk("c0 pin_wait", bus.current_state, 8'h02);
        pin(16'h1234);
        chk("c0 menu", bus.current_state, 8'h04);
        chk("c0 err",  bus.error_code, 8'h00);
        for (int i = 0; i < 13; i++) begin
            do_req($sformatf("vec%0d", i), tbl[i].strb, tbl[i].amt, tbl[i].e, tbl[i].ok, tbl[i].bal);
            model_op(0, tbl[i].strb, longint'(tbl[i].amt), e);
        end

        // PIN change waits in EXEC for the new value
        bus.pin_change_req = 1'b1;
        step();
        bus.pin_change_req = 1'b0;
        chk("pinchg exec", bus.current_state, 8'h05);
        step();
        chk("pinchg wait", bus.current_state, 8'h05);
        pin(16'h5678);
        chk("pinchg result", bus.current_state, 8'h06);
        chk("pinchg success", bus.transaction_success, 1'b1);
        bus.transaction_done = 1'b1;
        step();
        bus.transaction_done = 1'b0;
        end_sess();
        m_pin[0] = 'h5678;
        insert(0);
        pin(16'h1234);
        chk("oldpin err",   bus.error_code, 8'h02);
        chk("oldpin state", bus.current_state, 8'h02);
        pin(16'h5678);
        chk("newpin state", bus.current_state, 8'h04);
        chk("newpin err",   bus.error_code, 8'h00);
        end_sess();

        // Three wrong PINs lock card 1 persistently
        insert(1);
        for (int k = 0; k < 3; k++) begin
            pin(16'h1111);
            chk($sformatf("lock err%0d", k),   bus.error_code, (k < 2) ? 8'h02 : 8'h03);
            chk($sformatf("lock state%0d", k), bus.current_state, (k < 2) ? 8'h02 : 8'h07);
        end
        m_lock[1] = 1'b1;
        pull();
        insert(1);
        chk("locked err",   bus.error_code, 8'h03);
        chk("locked state", bus.current_state, 8'h07);
        pull();

        // Out-of-range card
        insert(255);
        chk("badcard err",   bus.error_code, 8'h01);
        chk("badcard eject", bus.card_eject, 1'b1);
        pull();

        // Inactivity in MENU: still there after TIMEOUT_CYC-1 idle cycles, ejected at TIMEOUT_CYC
        insert(2);
        pin(16'(m_pin[2]));
        chk("tmo menu", bus.current_state, 8'h04);
        repeat (999) step();
        chk("tmo edge", bus.current_state, 8'h04);
        step();
        chk("tmo state", bus.current_state, 8'h07);
        chk("tmo err",   bus.error_code, 8'h06);
        pull();

        // Card pulled while waiting for the PIN
        insert(2);
        bus.card_inserted = 1'b0;
        step();
        chk("pull state", bus.current_state, 8'h00);
        chk("pull err",   bus.error_code, 8'h07);
        step();
        chk("idle clears err", bus.error_code, 8'h00);

        // Card pulled during EXEC: the withdrawal must not commit
        insert(3);
        pin(16'(m_pin[3]));
        bus.withdrawal_req = 1'b1;
        bus.amount = 24'd50;
        step();
        bus.withdrawal_req = 1'b0;
        chk("abort exec", bus.current_state, 8'h05);
        bus.card_inserted = 1'b0;
        step();
        chk("abort state", bus.current_state, 8'h00);
        chk("abort err",   bus.error_code, 8'h07);
        step();
        insert(3);
        pin(16'(m_pin[3]));
        do_req("abort bal", 3'b001, 24'd0, 8'h00, 1'b1, 24'(m_bal[3]));
        end_sess();

        // Random sessions scored against the account model
        for (int sidx = 0; sidx < 60; sidx++) begin
            c = $urandom_range(0, 9);
            insert(c);
            if (c >= NACC || m_lock[c]) begin
                chk("rnd reject state", bus.current_state, 8'h07);
                chk("rnd reject err",   bus.error_code, (c >= NACC) ? 8'h01 : 8'h03);
                pull();
                continue;
            end
            if ($urandom_range(0, 3) == 0) begin
                pin(16'(m_pin[c] ^ 'h0101));
                m_tries[c]++;
                if (m_tries[c] >= 3) begin
                    m_lock[c] = 1'b1;
                    chk("rnd lock err", bus.error_code, 8'h03);
                    pull();
                    continue;
                end
                chk("rnd badpin err",   bus.error_code, 8'h02);
                chk("rnd badpin state", bus.current_state, 8'h02);
            end
            pin(16'(m_pin[c]));
            m_tries[c] = 0;
            chk("rnd menu", bus.current_state, 8'h04);
            nops = $urandom_range(1, 4);
            for (int o = 0; o < nops; o++) begin
                s = 3'($urandom_range(1, 7));
                case ($urandom_range(0, 4))
                    0:       a = 24'd0;
                    1, 2:    a = 24'($urandom_range(1, 400));
                    3:       a = 24'($urandom_range(401, 3000));
                    default: a = 24'($urandom_range(0, 24'hFFFFFF));
                endcase
                model_op(c, s, longint'(a), e);
                do_req($sformatf("rnd%0d.%0d", sidx, o), s, a, e, (e == 8'h00), 24'(m_bal[c]));
            end
            end_sess();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/atm_multi_account_ctrl.md
Name: atm_multi_account_ctrl

Overview:
Parametrised multi-account ATM session controller. It holds NUM_ACCTS account records on chip, each with a balance, a PIN, a fail counter and a lock flag. It runs one card session at a time: card check, PIN handshake, then a menu of transactions. Compared with the single-account controller it adds an entry-strobe handshake, persistent per-card lockout, an inactivity timeout, a per-session withdrawal limit and deposit overflow protection.

Parameters:
NUM_ACCTS, 8, number of accounts; card numbers 0..NUM_ACCTS-1 are valid
CARD_W, 8, card number width
PIN_W, 16, PIN width
BAL_W, 24, balance and amount width
INIT_BAL, 1000, balance of every account at reset
PIN_BASE, 16'h1234, reset PIN of account i is PIN_BASE+i
MAX_TRIES, 3, consecutive wrong PINs before the card locks
TIMEOUT_CYC, 1000, idle cycles before a session is aborted
WDL_LIMIT, 500, maximum total withdrawal per session

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
card_inserted  in  1  level; high while a card is present
card_number_input  in  CARD_W  card id, sampled in CARD_CHECK
pin_input  in  PIN_W  PIN value or new PIN
pin_valid  in  1  one-cycle strobe; pin_input is valid
balance_req / withdrawal_req / deposit_req / pin_change_req  in  1 each  one-cycle request strobes, accepted in MENU only
amount  in  BAL_W  transaction amount, sampled with the request
transaction_done  in  1  acknowledge of the result
end_session  in  1  user ends the session
current_state  out  8  state code
balance  out  BAL_W  balance of the active account
transaction_success  out  1  result flag
error_code  out  8  last error
card_eject  out  1  high while in EJECT

Behaviour:
- Reset values: current_state=0x00, balance=0, transaction_success=0, error_code=0x00, card_eject=0. All accounts are set to INIT_BAL and PIN_BASE+i, unlocked, tries=0, session total=0.
- State codes:
  - IDLE 00, CARD_CHECK 01, PIN_WAIT 02, PIN_CHECK 03, MENU 04, EXEC 05, RESULT 06, EJECT 07.
- IDLE: card_inserted high -> CARD_CHECK next cycle. error_code clears to 0x00 and the session total clears.
- CARD_CHECK (1 cycle):
  - card >= NUM_ACCTS -> error 0x01, EJECT.
  - card locked -> error 0x03, EJECT.
  - otherwise latch the account index and go to PIN_WAIT.
- PIN_WAIT: pin_valid -> PIN_CHECK.
- PIN_CHECK (1 cycle):
  - PIN match -> tries=0, error 0x00, MENU.
  - Mismatch -> tries+1. If tries reaches MAX_TRIES: set lock, error 0x03, EJECT. Otherwise error 0x02, back to PIN_WAIT.
  - Lock persists until rst_n.
- MENU:
  - Request priority when strobes coincide: balance > withdrawal > deposit > pin_change. Only the winner executes.
  - end_session -> EJECT.
  - The accepted request and amount are registered, then EXEC.
- EXEC (1 cycle), with the outcome written in the same edge:
  - Balance: always succeeds.
  - Withdrawal:
    - amount=0 -> error 0x09.
    - amount > balance -> error 0x04.
    - session total + amount > WDL_LIMIT -> error 0x05.
    - otherwise debit the account and add amount to the session total.
  - Deposit:
    - amount=0 -> error 0x09.
    - balance + amount > 2^BAL_W-1 -> error 0x08; compare at BAL_W+1 bits, no wrap.
    - otherwise credit the account.
  - PIN change: the next pin_valid value becomes the new PIN. EXEC waits for it, subject to the timeout.
  - Success sets error 0x00. Failure leaves the account untouched.
  - Always proceed to RESULT.
- RESULT:
  - transaction_success is held 1 on success, 0 on failure.
  - balance shows the active account balance.
  - transaction_done -> MENU and transaction_success clears.
- EJECT: card_eject=1. card_inserted low -> IDLE. balance clears to 0.
- Card removal: card_inserted low in any state other than IDLE/EJECT -> error 0x07, IDLE next cycle. A transaction in EXEC in that cycle does not commit.
- Timeout:
  - A counter runs in PIN_WAIT, MENU, EXEC(pin change) and RESULT.
  - It clears on any strobe and on every state change.
  - When it reaches TIMEOUT_CYC-1: error 0x06, EJECT.
- error_code persists until overwritten or IDLE.

Optional Feature:
ATM_TRANSFER_EN
- Defined: ports xfer_req (1) and xfer_dest (CARD_W) are added. xfer_req ranks lowest in priority.
  - Fails with:
    - 0x01 if the destination is invalid or equal to the source.
    - 0x04 if amount > balance.
    - 0x08 if the destination would overflow.
    - 0x09 if amount=0.
  - On success, source and destination update in the same cycle. Transfers do not count toward WDL_LIMIT.
- Undefined: these ports are absent and no transfer logic is built.

Test Plan:
- Card 0x00, PIN 0x1234 strobe, balance_req, transaction_done -> MENU, success=1, balance=1000, error 00.
- Card 0x01, PIN 0x1111 three times -> error 02, 02, then 03; EJECT. Reinsert card 0x01 -> CARD_CHECK then error 03, EJECT.
- Card 0, withdraw 0xFFFF -> error 04; withdraw 300 -> balance 700; withdraw 250 -> error 05, balance stays 700.
- Card 0, deposit 2^24-1 -> error 08, balance unchanged; deposit 0x100 -> balance +256, success=1.
- Card 0, pin_change with 0x5678, then end session. Reinsert with 0x1234 -> error 02; with 0x5678 -> MENU.
- Card 0xFF -> error 01. Valid session idle TIMEOUT_CYC cycles in MENU -> error 06, EJECT. Card pulled in PIN_WAIT -> error 07, IDLE.
